// File: rtl/smc_arb_lite16_if.sv
`default_nettype none
// ============================================================================
// Module      : smc_arb_lite16_if
// Description : Requester/SMC handshake bundle for the SMC access arbiter.
// Revision    : 1.0
// ============================================================================
interface smc_arb_lite16_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req16;
    logic [4*NUM_REQ-1:0] req_beats16;
    logic                 smc_done16;
    logic                 smc_idle16;
    logic                 new_access16;
    logic                 mac_done16;
    logic [NUM_REQ-1:0]   gnt16;
    logic [ID_W-1:0]      gnt_id16;
    logic [NUM_REQ-1:0]   beat_ack16;
    logic [NUM_REQ-1:0]   last_ack16;
    logic                 busy16;

    modport slave (
        input  req16, req_beats16, smc_done16, smc_idle16,
        output new_access16, mac_done16, gnt16, gnt_id16,
               beat_ack16, last_ack16, busy16
    );

    modport master (
        output req16, req_beats16, smc_done16, smc_idle16,
        input  new_access16, mac_done16, gnt16, gnt_id16,
               beat_ack16, last_ack16, busy16
    );
endinterface
`default_nettype wire

// File: rtl/smc_arb_lite16.sv
`default_nettype none
// ============================================================================
// Module      : smc_arb_lite16
// Description : Round-robin arbiter and burst sequencer sharing one SMC.
// Revision    : 1.0
// ============================================================================
module smc_arb_lite16 #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input wire                sys_clk16,
    input wire                n_sys_reset16,
    smc_arb_lite16_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           beat_cnt_q, beat_cnt_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 busy_q;

    logic                 w_pick_vld;
    logic [ID_W-1:0]      w_pick_id;
    logic                 w_in_access;
    logic                 w_abort;
    logic                 w_last;
    logic                 w_done_acc;

    // Scan downward so the lowest offset from rr_ptr is the one left standing.
    always_comb begin
        logic [ID_W-1:0] cand;
        cand       = '0;
        w_pick_vld = 1'b0;
        w_pick_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (bus.req16[cand]) begin
                w_pick_vld = 1'b1;
                w_pick_id  = cand;
            end
        end
    end

    assign w_in_access = (state_q == S_ACCESS);
    assign w_abort     = ~bus.req16[gnt_id_q];
    assign w_last      = (beat_cnt_q == 4'd0) | w_abort;
    assign w_done_acc  = w_in_access & bus.smc_done16;

    assign bus.new_access16 = w_in_access & ~(bus.smc_done16 & w_last);
    assign bus.mac_done16   = w_in_access & w_last;
    assign bus.beat_ack16   = gnt_q & {NUM_REQ{w_done_acc}};
    assign bus.last_ack16   = gnt_q & {NUM_REQ{w_done_acc & w_last}};
    assign bus.gnt16        = gnt_q;
    assign bus.gnt_id16     = gnt_id_q;
    assign bus.busy16       = busy_q;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        case (state_q)
            S_IDLE: begin
                if (w_pick_vld && bus.smc_idle16) begin
                    gnt_d      = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_id;
                    gnt_id_d   = w_pick_id;
                    beat_cnt_d = bus.req_beats16[{w_pick_id, 2'b00} +: 4];
                    state_d    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (bus.smc_done16) begin
                    if (w_last) begin
                        gnt_d   = '0;
                        state_d = S_RELEASE;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 4'd1;
                    end
                end
            end
            S_RELEASE: begin
                gnt_d    = '0;
                rr_ptr_d = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk16 or negedge n_sys_reset16) begin
        if (!n_sys_reset16) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end
endmodule
`default_nettype wire
